// File: rtl/playlist_if.sv
// Button pulses and player-control outputs shared between the playlist controller and its environment.
interface playlist_if #(
  parameter int SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              mode_button;
  logic              song_done;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic [1:0]        state;
  logic [1:0]        repeat_mode;

  modport master (
    output play_button, next_button, prev_button, mode_button, song_done,
    input  play, reset_player, song, state, repeat_mode
  );

  modport slave (
    input  play_button, next_button, prev_button, mode_button, song_done,
    output play, reset_player, song, state, repeat_mode
  );
endinterface

// File: rtl/playlist_mcu.sv
// Playlist controller: sequences songs for song_player with prev/next, repeat modes,
// end-of-playlist stop and a multi-cycle player reset on every track change.
module playlist_mcu #(
  parameter int NUM_SONGS     = 4,
  parameter int SONG_W        = 2,
  parameter int CHANGE_CYCLES = 2,
  parameter int AUTO_RESUME   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  playlist_if.slave   bus
);
  localparam int CNT_W = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CHANGE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'b00,
    ST_PLAY   = 2'b01,
    ST_CHANGE = 2'b10,
    ST_END    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    RPT_OFF = 2'b00,
    RPT_ALL = 2'b01,
    RPT_ONE = 2'b10
  } rpt_t;

  state_t            r_state;
  rpt_t              r_mode;
  logic [SONG_W-1:0] r_song;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resume;

  state_t            w_state_nxt;
  rpt_t              w_mode_nxt;
  logic [SONG_W-1:0] w_song_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_resume_nxt;
  logic              w_auto;

  // Explicit wrap at NUM_SONGS so non-power-of-two playlists stay in range.
  function automatic logic [SONG_W-1:0] f_inc(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] f_dec(input logic [SONG_W-1:0] s);
    return (s == '0) ? LAST_SONG : s - SONG_W'(1);
  endfunction

  function automatic rpt_t f_mode_step(input rpt_t m);
    case (m)
      RPT_OFF: return RPT_ALL;
      RPT_ALL: return RPT_ONE;
      default: return RPT_OFF;
    endcase
  endfunction

  assign w_auto = (AUTO_RESUME != 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_PAUSE;
      r_mode   <= RPT_OFF;
      r_song   <= '0;
      r_cnt    <= '0;
      r_resume <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_song   <= w_song_nxt;
      r_cnt    <= w_cnt_nxt;
      r_resume <= w_resume_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_song_nxt   = r_song;
    w_cnt_nxt    = r_cnt;
    w_resume_nxt = r_resume;
    w_mode_nxt   = bus.mode_button ? f_mode_step(r_mode) : r_mode;

    // Every branch that leaves for CHANGE loads the target song and clears the counter.
    case (r_state)
      ST_PAUSE: begin
        if (bus.play_button) begin
          w_state_nxt = ST_PLAY;
        end else if (bus.next_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = f_inc(r_song); w_cnt_nxt = '0; w_resume_nxt = 1'b0;
        end else if (bus.prev_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = f_dec(r_song); w_cnt_nxt = '0; w_resume_nxt = 1'b0;
        end
      end
      ST_PLAY: begin
        if (bus.play_button) begin
          w_state_nxt = ST_PAUSE;
        end else if (bus.next_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = f_inc(r_song); w_cnt_nxt = '0; w_resume_nxt = w_auto;
        end else if (bus.prev_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = f_dec(r_song); w_cnt_nxt = '0; w_resume_nxt = w_auto;
        end else if (bus.song_done) begin
          if (r_mode == RPT_ONE) begin
            w_state_nxt = ST_CHANGE; w_cnt_nxt = '0; w_resume_nxt = 1'b1;
          end else if (r_mode == RPT_OFF && r_song == LAST_SONG) begin
            w_state_nxt = ST_END;
          end else begin
            w_state_nxt = ST_CHANGE; w_song_nxt = f_inc(r_song); w_cnt_nxt = '0; w_resume_nxt = 1'b1;
          end
        end
      end
      ST_CHANGE: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = r_resume ? ST_PLAY : ST_PAUSE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_END: begin
        if (bus.play_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = '0; w_cnt_nxt = '0; w_resume_nxt = 1'b1;
        end else if (bus.next_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = '0; w_cnt_nxt = '0; w_resume_nxt = 1'b0;
        end else if (bus.prev_button) begin
          w_state_nxt = ST_CHANGE; w_song_nxt = LAST_SONG; w_cnt_nxt = '0; w_resume_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_PAUSE;
      end
    endcase
  end

  assign bus.play         = (r_state == ST_PLAY);
  assign bus.reset_player = (r_state == ST_CHANGE);
  assign bus.state        = r_state;
  assign bus.song         = r_song;
  assign bus.repeat_mode  = r_mode;
endmodule

// File: tb/tb_playlist_mcu.sv
// Scoreboard bench for playlist_mcu with NUM_SONGS=3; a second instance with AUTO_RESUME=0 shares the stimulus.
module tb_playlist_mcu;
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_PLAY = 5'b10000;
  localparam logic [4:0] B_NEXT = 5'b01000;
  localparam logic [4:0] B_PREV = 5'b00100;
  localparam logic [4:0] B_MODE = 5'b00010;
  localparam logic [4:0] B_DONE = 5'b00001;

  localparam logic [1:0] PAUSE = 2'b00, PLAY = 2'b01, CHG = 2'b10, ENDS = 2'b11;
  localparam logic [1:0] OFF = 2'b00, ALL = 2'b01, ONE = 2'b10;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [1:0] song;
    logic [1:0] mode;
    bit         chkb;
    logic [1:0] bst;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  event chk_ev;

  playlist_if #(.SONG_W(2)) bus_a ();
  playlist_if #(.SONG_W(2)) bus_b ();

  playlist_mcu #(.NUM_SONGS(3), .SONG_W(2), .CHANGE_CYCLES(2), .AUTO_RESUME(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );
  playlist_mcu #(.NUM_SONGS(3), .SONG_W(2), .CHANGE_CYCLES(2), .AUTO_RESUME(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  assign bus_b.play_button = bus_a.play_button;
  assign bus_b.next_button = bus_a.next_button;
  assign bus_b.prev_button = bus_a.prev_button;
  assign bus_b.mode_button = bus_a.mode_button;
  assign bus_b.song_done   = bus_a.song_done;

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] btn);
    {bus_a.play_button, bus_a.next_button, bus_a.prev_button, bus_a.mode_button, bus_a.song_done} = btn;
  endtask

  // Expectation describes the outputs after the next rising edge.
  task automatic step(input string nm, input logic [4:0] btn, input logic [1:0] st,
                      input logic [1:0] sg, input logic [1:0] md,
                      input bit chkb = 1'b0, input logic [1:0] bst = 2'b00);
    exp_t e;
    @(negedge clk);
    drive(btn);
    e.name = nm; e.st = st; e.song = sg; e.mode = md; e.chkb = chkb; e.bst = bst;
    q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(negedge clk);
    drive(B_NONE);
    reset_n = 1'b0;
    e.name = nm; e.st = PAUSE; e.song = 2'd0; e.mode = OFF; e.chkb = 1'b1; e.bst = PAUSE;
    q.push_back(e);
    ->chk_ev;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic exp_play, exp_rp;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_play = (e.st == PLAY);
        exp_rp   = (e.st == CHG);
        n_total++;
        if (bus_a.state === e.st && bus_a.song === e.song && bus_a.repeat_mode === e.mode &&
            bus_a.play === exp_play && bus_a.reset_player === exp_rp &&
            (!e.chkb || (bus_b.state === e.bst && bus_b.play === (e.bst == PLAY) &&
                         bus_b.reset_player === (e.bst == CHG)))) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got state=%b song=%0d mode=%b play=%b rp=%b b_state=%b, expected state=%b song=%0d mode=%b play=%b rp=%b b_state=%b (b checked=%0d)",
                   e.name, bus_a.state, bus_a.song, bus_a.repeat_mode, bus_a.play, bus_a.reset_player,
                   bus_b.state, e.st, e.song, e.mode, exp_play, exp_rp, e.bst, e.chkb);
        end
      end
    end
  end

  initial begin : stimulus
    drive(B_NONE);
    do_reset("reset");

    // next x3 from PAUSE, 2-cycle change each, back to PAUSE
    step("t1_next1", B_NEXT, CHG,   2'd1, OFF, 1, CHG);
    step("t1_chg1b", B_NONE, CHG,   2'd1, OFF, 1, CHG);
    step("t1_pause1", B_NONE, PAUSE, 2'd1, OFF, 1, PAUSE);
    step("t1_next2", B_NEXT, CHG,   2'd2, OFF, 1, CHG);
    step("t1_chg2b", B_NONE, CHG,   2'd2, OFF, 1, CHG);
    step("t1_pause2", B_NONE, PAUSE, 2'd2, OFF, 1, PAUSE);
    step("t1_next0", B_NEXT, CHG,   2'd0, OFF, 1, CHG);
    step("t1_chg0b", B_NONE, CHG,   2'd0, OFF, 1, CHG);
    step("t1_pause0", B_NONE, PAUSE, 2'd0, OFF, 1, PAUSE);

    // prev from PLAY on song 0; auto-resume vs not
    step("t2_play", B_PLAY, PLAY, 2'd0, OFF, 1, PLAY);
    step("t2_prev", B_PREV, CHG,  2'd2, OFF, 1, CHG);
    step("t2_chgb", B_NONE, CHG,  2'd2, OFF, 1, CHG);
    step("t2_resume", B_NONE, PLAY, 2'd2, OFF, 1, PAUSE);
    do_reset("t2_reset");

    // repeat OFF, end of playlist
    step("t3_prev", B_PREV, CHG,   2'd2, OFF);
    step("t3_chgb", B_NONE, CHG,   2'd2, OFF);
    step("t3_pause", B_NONE, PAUSE, 2'd2, OFF);
    step("t3_play", B_PLAY, PLAY,  2'd2, OFF);
    step("t3_done_end", B_DONE, ENDS, 2'd2, OFF);
    step("t3_end_hold", B_NONE, ENDS, 2'd2, OFF);
    step("t3_end_play", B_PLAY, CHG,  2'd0, OFF);
    step("t3_chgb", B_NONE, CHG,  2'd0, OFF);
    step("t3_resume", B_NONE, PLAY, 2'd0, OFF);

    // repeat ONE then ALL
    step("t4_mode_all", B_MODE, PLAY, 2'd0, ALL);
    step("t4_mode_one", B_MODE, PLAY, 2'd0, ONE);
    step("t4_next", B_NEXT, CHG,  2'd1, ONE);
    step("t4_chgb", B_NONE, CHG,  2'd1, ONE);
    step("t4_play1", B_NONE, PLAY, 2'd1, ONE);
    step("t4_done_one", B_DONE, CHG, 2'd1, ONE);
    step("t4_chgb_one", B_NONE, CHG, 2'd1, ONE);
    step("t4_replay1", B_NONE, PLAY, 2'd1, ONE);
    step("t4_mode_off", B_MODE, PLAY, 2'd1, OFF);
    step("t4_mode_all2", B_MODE, PLAY, 2'd1, ALL);
    step("t4_next2", B_NEXT, CHG,  2'd2, ALL);
    step("t4_chgb2", B_NONE, CHG,  2'd2, ALL);
    step("t4_play2", B_NONE, PLAY, 2'd2, ALL);
    step("t4_done_all", B_DONE, CHG, 2'd0, ALL);
    step("t4_chgb_all", B_NONE, CHG, 2'd0, ALL);
    step("t4_wrap_play", B_NONE, PLAY, 2'd0, ALL);
    step("t4_mode_done", B_MODE | B_DONE, CHG, 2'd1, ONE);
    step("t4_md_chgb", B_NONE, CHG,  2'd1, ONE);
    step("t4_md_play", B_NONE, PLAY, 2'd1, ONE);

    // next+done together, play ignored in CHANGE
    step("t5_next_done", B_NEXT | B_DONE, CHG, 2'd2, ONE);
    step("t5_play_in_chg", B_PLAY, CHG, 2'd2, ONE);
    step("t5_resume", B_NONE, PLAY, 2'd2, ONE);
    step("t5_pause", B_PLAY, PAUSE, 2'd2, ONE);
    step("t5_done_ignored", B_DONE, PAUSE, 2'd2, ONE);

    // async reset in 2nd CHANGE cycle
    step("t6_prev", B_PREV, CHG, 2'd1, ONE);
    step("t6_chgb", B_NONE, CHG, 2'd1, ONE);
    do_reset("t6_reset_mid_change");
    step("t6_after", B_NONE, PAUSE, 2'd0, OFF, 1, PAUSE);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
